// File: rtl/mem_stage.sv
// Memory stage of the 16-bit pipeline: issues one request per access to a
// multi-cycle data memory, stalls upstream until mem_done, and owns MEM/WB.
module mem_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instruction,
    input  logic [15:0] data_out,
    input  logic [15:0] data_two,
    input  logic [2:0]  write_sel,
    input  logic        Reg_write,
    input  logic        Mem_read,
    input  logic        Mem_write,
    input  logic        Mem_reg,
    input  logic        Mem_en,
    input  logic        halt,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_done,
    input  logic        mem_stall,
    output logic        stall_o,
    output logic [15:0] wb_instruction_o,
    output logic [15:0] wb_data_o,
    output logic [2:0]  wb_write_sel_o,
    output logic        wb_reg_write_o,
    output logic        wb_halt_o,
    output logic        err_o
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;

    logic memop;
    logic misalign;
    logic req_ok;
    logic issue;
    logic timeout;
    logic pass;
    logic mem_complete;
    logic fault;

    logic [15:0] wb_data_nxt;
    logic        wb_reg_write_nxt;
    logic        wb_halt_nxt;

    assign memop    = Mem_en & (Mem_read | Mem_write);
    assign misalign = memop & data_out[0];
    // Once err_o is set, memory is never touched again until reset.
    assign req_ok   = memop & ~misalign & ~err_o;
    assign issue    = ~rst & (state == IDLE) & req_ok & ~mem_stall;
    assign timeout  = (state == BUSY) & ~mem_done & (cnt == CNT_LAST);

    assign mem_addr  = data_out;
    assign mem_wdata = data_two;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == BUSY && !mem_done)
                cnt <= cnt + CNT_W'(1);
            else
                cnt <= '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (issue && !mem_done) state_nxt = BUSY;
            BUSY: if (mem_done || timeout) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_rd       = issue & Mem_read;
        mem_wr       = issue & Mem_write;
        stall_o      = 1'b0;
        pass         = 1'b0;
        mem_complete = 1'b0;
        fault        = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    pass         = ~memop;
                    mem_complete = issue & mem_done;
                    fault        = memop & ~req_ok;
                    stall_o      = req_ok & (mem_stall | ~mem_done);
                end
                BUSY: begin
                    mem_complete = mem_done;
                    fault        = timeout;
                    stall_o      = ~mem_done;
                end
                default: ;
            endcase
        end
        wb_data_nxt      = (mem_complete & Mem_reg) ? mem_rdata : data_out;
        wb_reg_write_nxt = (pass | mem_complete) & Reg_write;
        wb_halt_nxt      = fault | ((pass | mem_complete) & halt);
    end

    // MEM/WB register boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_instruction_o <= '0;
            wb_data_o        <= '0;
            wb_write_sel_o   <= '0;
            wb_reg_write_o   <= 1'b0;
            wb_halt_o        <= 1'b0;
            err_o            <= 1'b0;
        end else begin
            wb_instruction_o <= instruction;
            wb_data_o        <= wb_data_nxt;
            wb_write_sel_o   <= write_sel;
            wb_reg_write_o   <= wb_reg_write_nxt;
            wb_halt_o        <= wb_halt_nxt;
            err_o            <= err_o | fault;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a cycle-level reference model pushes the
// expected handshake outputs and MEM/WB contents; two monitors pop and compare.
module tb_mem_stage;

    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instruction, data_out, data_two, mem_rdata;
    logic [2:0]  write_sel;
    logic        Reg_write, Mem_read, Mem_write, Mem_reg, Mem_en, halt;
    logic        mem_done, mem_stall;
    logic [15:0] mem_addr, mem_wdata, wb_instruction_o, wb_data_o;
    logic        mem_rd, mem_wr, stall_o, wb_reg_write_o, wb_halt_o, err_o;
    logic [2:0]  wb_write_sel_o;

    mem_stage #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .data_out(data_out),
        .data_two(data_two), .write_sel(write_sel), .Reg_write(Reg_write),
        .Mem_read(Mem_read), .Mem_write(Mem_write), .Mem_reg(Mem_reg),
        .Mem_en(Mem_en), .halt(halt), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata),
        .mem_done(mem_done), .mem_stall(mem_stall), .stall_o(stall_o),
        .wb_instruction_o(wb_instruction_o), .wb_data_o(wb_data_o),
        .wb_write_sel_o(wb_write_sel_o), .wb_reg_write_o(wb_reg_write_o),
        .wb_halt_o(wb_halt_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd, wr, stall;
        logic [15:0] addr, wdata;
    } comb_t;

    typedef struct {
        bit          full;
        logic [15:0] instr, data;
        logic [2:0]  sel;
        logic        rw, halt, err;
    } wb_t;

    comb_t comb_q[$];
    wb_t   wb_q[$];
    int    checks = 0;
    int    failures = 0;

    // Reference state: waiting on memory, BUSY cycles already spent, sticky error.
    bit m_busy = 0;
    int m_waited = 0;
    bit m_err = 0;
    bit m_stall = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
        end
    endfunction

    task automatic model_step();
        comb_t c;
        wb_t   w;
        bit    memop;
        memop   = Mem_en && (Mem_read || Mem_write);
        c.addr  = data_out;
        c.wdata = data_two;
        c.rd = 0; c.wr = 0; c.stall = 0;
        w.full = 0; w.instr = instruction; w.data = data_out; w.sel = write_sel;
        w.rw = 0; w.halt = 0;
        if (rst) begin
            m_busy = 0; m_waited = 0; m_err = 0;
            w.full = 1; w.instr = 0; w.data = 0; w.sel = 0;
        end else if (!m_busy) begin
            if (!memop) begin
                w.full = 1; w.rw = Reg_write; w.halt = halt;
            end else if (m_err || data_out[0]) begin
                m_err = 1; w.halt = 1;
            end else if (mem_stall) begin
                c.stall = 1;
            end else begin
                c.rd = Mem_read; c.wr = Mem_write;
                if (mem_done) begin
                    w.full = 1; w.rw = Reg_write; w.halt = halt;
                    if (Mem_reg) w.data = mem_rdata;
                end else begin
                    c.stall = 1; m_busy = 1; m_waited = 0;
                end
            end
        end else begin
            if (mem_done) begin
                w.full = 1; w.rw = Reg_write; w.halt = halt;
                if (Mem_reg) w.data = mem_rdata;
                m_busy = 0;
            end else if (m_waited + 1 == TIMEOUT) begin
                m_err = 1; w.halt = 1; m_busy = 0; c.stall = 1;
            end else begin
                m_waited++; c.stall = 1;
            end
        end
        w.err   = m_err;
        m_stall = c.stall;
        comb_q.push_back(c);
        wb_q.push_back(w);
    endtask

    task automatic step();
        model_step();
        @(negedge clk);
    endtask

    task automatic set_ex(input logic [15:0] ins, input logic [15:0] dout,
                          input logic [15:0] dtwo, input logic [2:0] sel,
                          input logic rw, input logic rd, input logic wr,
                          input logic mreg, input logic en, input logic hlt);
        instruction = ins; data_out = dout; data_two = dtwo; write_sel = sel;
        Reg_write = rw; Mem_read = rd; Mem_write = wr; Mem_reg = mreg;
        Mem_en = en; halt = hlt;
    endtask

    task automatic rand_ex();
        int k;
        instruction = 16'($urandom);
        data_out    = 16'($urandom);
        if ($urandom_range(0, 9) != 0) data_out[0] = 1'b0;
        data_two  = 16'($urandom);
        write_sel = 3'($urandom_range(0, 7));
        Reg_write = 1'($urandom_range(0, 1));
        Mem_en    = ($urandom_range(0, 9) < 6);
        k = $urandom_range(0, 9);
        Mem_read  = (k < 5) || (k == 9);
        Mem_write = (k >= 5);
        Mem_reg   = 1'($urandom_range(0, 1));
        halt      = ($urandom_range(0, 19) == 0);
    endtask

    task automatic rand_all();
        rand_ex();
        mem_rdata = 16'($urandom);
        mem_done  = 1'($urandom_range(0, 1));
        mem_stall = 1'($urandom_range(0, 1));
    endtask

    // Registered outputs: compared just after the edge that loaded them.
    initial begin
        wb_t e;
        forever begin
            @(posedge clk);
            #1;
            if (wb_q.size() > 0) begin
                e = wb_q.pop_front();
                if (e.full) begin
                    chk("wb_instruction", 32'(wb_instruction_o), 32'(e.instr));
                    chk("wb_data", 32'(wb_data_o), 32'(e.data));
                    chk("wb_write_sel", 32'(wb_write_sel_o), 32'(e.sel));
                end
                chk("wb_reg_write", 32'(wb_reg_write_o), 32'(e.rw));
                chk("wb_halt", 32'(wb_halt_o), 32'(e.halt));
                chk("err", 32'(err_o), 32'(e.err));
            end
        end
    end

    // Combinational handshake outputs: compared mid-cycle after inputs settle.
    initial begin
        comb_t e;
        forever begin
            @(negedge clk);
            #2;
            if (comb_q.size() > 0) begin
                e = comb_q.pop_front();
                chk("mem_rd", 32'(mem_rd), 32'(e.rd));
                chk("mem_wr", 32'(mem_wr), 32'(e.wr));
                chk("stall", 32'(stall_o), 32'(e.stall));
                chk("mem_addr", 32'(mem_addr), 32'(e.addr));
                chk("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
            end
        end
    end

    initial begin
        rst = 1'b1;
        rand_all();
        @(negedge clk);

        // reset with random inputs
        step();
        rand_all();
        step();
        rst = 1'b0;
        chk("reset_wb_reg_write", 32'(wb_reg_write_o), 32'd0);
        chk("reset_err", 32'(err_o), 32'd0);
        mem_done = 0; mem_stall = 0;

        // ALU pass-through
        set_ex(16'h1111, 16'h1234, 16'h0000, 3'd3, 1, 0, 0, 0, 0, 0);
        step();
        chk("pass_data", 32'(wb_data_o), 32'h1234);
        chk("pass_sel", 32'(wb_write_sel_o), 32'd3);
        chk("pass_rw", 32'(wb_reg_write_o), 32'd1);

        // load with done three cycles after issue
        set_ex(16'h2222, 16'h0040, 16'h0000, 3'd5, 1, 1, 0, 1, 1, 0);
        step(); step(); step();
        mem_done = 1; mem_rdata = 16'hBEEF;
        step();
        mem_done = 0;
        chk("load_data", 32'(wb_data_o), 32'hBEEF);
        chk("load_rw", 32'(wb_reg_write_o), 32'd1);

        // zero-wait store
        set_ex(16'h3333, 16'h0010, 16'h00AA, 3'd2, 1, 0, 1, 0, 1, 0);
        mem_done = 1;
        step();
        mem_done = 0;
        chk("store_rw", 32'(wb_reg_write_o), 32'd1);

        // memory busy for two cycles, spurious done ignored, then issue
        set_ex(16'h4444, 16'h0020, 16'h0000, 3'd1, 1, 1, 0, 1, 1, 0);
        mem_stall = 1; mem_done = 1; mem_rdata = 16'hDEAD;
        step(); step();
        mem_stall = 0; mem_done = 0;
        step();
        mem_done = 1; mem_rdata = 16'h5A5A;
        step();
        mem_done = 0;
        chk("stall_load_data", 32'(wb_data_o), 32'h5A5A);

        // read and write together
        set_ex(16'h5555, 16'h0030, 16'h0F0F, 3'd4, 1, 1, 1, 0, 1, 0);
        mem_done = 1;
        step();
        mem_done = 0;

        // misaligned load
        set_ex(16'h6666, 16'h0041, 16'h0000, 3'd6, 1, 1, 0, 1, 1, 0);
        step();
        chk("misalign_err", 32'(err_o), 32'd1);
        chk("misalign_halt", 32'(wb_halt_o), 32'd1);
        chk("misalign_rw", 32'(wb_reg_write_o), 32'd0);

        // aligned access after error: no request, halt
        set_ex(16'h7777, 16'h0050, 16'h0000, 3'd7, 1, 1, 0, 1, 1, 0);
        mem_done = 1;
        step();
        mem_done = 0;
        chk("post_err_halt", 32'(wb_halt_o), 32'd1);
        set_ex(16'h7878, 16'h0099, 16'h0000, 3'd2, 1, 0, 0, 0, 0, 0);
        step();

        // timeout after TIMEOUT BUSY cycles
        rst = 1; step(); rst = 0;
        set_ex(16'h8888, 16'h0060, 16'h0000, 3'd3, 1, 1, 0, 1, 1, 0);
        repeat (TIMEOUT) step();
        chk("timeout_err_early", 32'(err_o), 32'd0);
        step();
        chk("timeout_err", 32'(err_o), 32'd1);
        chk("timeout_halt", 32'(wb_halt_o), 32'd1);
        set_ex(16'h8989, 16'h0002, 16'h0000, 3'd1, 1, 0, 0, 0, 0, 0);
        step();

        // reset in the second BUSY cycle, stale done afterwards
        rst = 1; step(); rst = 0;
        set_ex(16'h9999, 16'h0070, 16'h0000, 3'd4, 1, 1, 0, 1, 1, 0);
        step(); step();
        rst = 1;
        step();
        rst = 0;
        chk("busy_reset_rw", 32'(wb_reg_write_o), 32'd0);
        set_ex(16'hAAAA, 16'h0072, 16'h0000, 3'd5, 1, 0, 0, 1, 0, 0);
        mem_done = 1; mem_rdata = 16'hFFFF;
        step();
        mem_done = 0;
        chk("stale_done_data", 32'(wb_data_o), 32'h0072);

        // randomized traffic with upstream held while stalled
        for (int blk = 0; blk < 4; blk++) begin
            rst = 1; rand_all(); step(); rst = 0;
            for (int i = 0; i < 300; i++) begin
                if (!m_stall) rand_ex();
                mem_stall = ($urandom_range(0, 3) == 0);
                mem_done  = ($urandom_range(0, 99) < 35);
                mem_rdata = 16'($urandom);
                rst       = ($urandom_range(0, 199) == 0);
                step();
            end
        end

        rst = 0;
        @(negedge clk);
        @(negedge clk);
        chk("drain_wb_q", 32'(wb_q.size()), 32'd0);
        chk("drain_comb_q", 32'(comb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage 16-bit pipeline; consumes the EX/MEM pipeline-register outputs.
- Drives the multi-cycle data memory through a request/done handshake.
- Stalls the upstream pipeline while an access is outstanding.
- Owns the MEM/WB register, so every wb_* output is registered.

Parameters:
- TIMEOUT, 16: max BUSY cycles waiting for mem_done before a bus error is flagged; legal range 2..255.
- CNT_W, 8: width of the timeout counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- instruction  in  16  instruction from EX/MEM
- data_out  in  16  ALU result; also the memory address
- data_two  in  16  store data
- write_sel  in  3  destination register index
- Reg_write  in  1  writeback enable
- Mem_read  in  1  load
- Mem_write  in  1  store
- Mem_reg  in  1  1 = writeback memory data, 0 = writeback data_out
- Mem_en  in  1  memory access enable
- halt  in  1  HALT instruction marker
- mem_addr  out  16  memory address; always data_out
- mem_wdata  out  16  memory write data; always data_two
- mem_rd  out  1  one-cycle read request
- mem_wr  out  1  one-cycle write request
- mem_rdata  in  16  read data; valid when mem_done=1
- mem_done  in  1  access complete
- mem_stall  in  1  memory cannot accept a request this cycle
- stall_o  out  1  combinational; upstream holds EX/MEM and earlier stages while 1
- wb_instruction_o  out  16  registered instruction
- wb_data_o  out  16  registered writeback data
- wb_write_sel_o  out  3  registered destination register
- wb_reg_write_o  out  1  registered writeback enable
- wb_halt_o  out  1  registered halt
- err_o  out  1  sticky error: misaligned access or timeout

Behaviour:
- Definitions:
  - memop = Mem_en & (Mem_read | Mem_write)
  - misalign = memop & data_out[0]
- Reset (synchronous, rst=1 at edge):
  - state=IDLE, counter=0.
  - All wb_* outputs=0, err_o=0.
  - mem_rd=mem_wr=0 and stall_o=0 while rst=1.
- State machine has two states, IDLE and BUSY.
- IDLE, no memop:
  - Pass-through: next edge loads the MEM/WB register with wb_data_o=data_out, plus instruction, write_sel, Reg_write and halt.
  - stall_o=0; latency is 1 cycle.
- IDLE, memop & ~misalign & mem_stall=1:
  - No request issued; stall_o=1.
  - Stay in IDLE; MEM/WB loads a bubble (wb_reg_write_o=0, wb_halt_o=0).
- IDLE, memop & ~misalign & mem_stall=0 (issue cycle):
  - mem_rd=Mem_read, mem_wr=Mem_write for exactly this cycle.
  - If mem_done=1 in the same cycle: complete immediately, stall_o=0.
  - Otherwise: stall_o=1, go to BUSY, counter=0, load a bubble.
- BUSY:
  - mem_rd=mem_wr=0.
  - While mem_done=0: stall_o=1, counter+1 per cycle, bubble each cycle.
  - mem_done=1: complete, stall_o=0, return to IDLE.
  - counter reaching TIMEOUT-1 with mem_done=0: set err_o, load wb_halt_o=1 and wb_reg_write_o=0, return to IDLE, stall_o=1 that cycle.
- Complete:
  - MEM/WB loads wb_data_o = Mem_reg ? mem_rdata : data_out, plus instruction, write_sel, Reg_write and halt.
  - EX/MEM inputs are stable throughout, because upstream is held by stall_o.
- Misaligned access (memop with data_out[0]=1):
  - No mem_rd or mem_wr is issued.
  - Next edge: err_o=1, wb_halt_o=1, wb_reg_write_o=0; stall_o=0.
- err_o is sticky until rst. While err_o=1, subsequent memops issue no request and load wb_halt_o=1.
- Spurious mem_done in IDLE with no issue that cycle is ignored.
- mem_done and timeout in the same cycle: mem_done wins.
- rst while BUSY: return to IDLE; a later mem_done from the aborted access is ignored.
- Read and write both asserted: both requests issue; this is not flagged.

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs -> all wb_* outputs=0, err_o=0, mem_rd=mem_wr=0, stall_o=0.
- ALU pass-through: Mem_en=0, Reg_write=1, write_sel=3, data_out=0x1234 -> next edge wb_data_o=0x1234, wb_write_sel_o=3, wb_reg_write_o=1; stall_o stays 0.
- Load with 3-cycle latency: data_out=0x0040, Mem_read=1, Mem_reg=1, mem_done 3 cycles after issue with mem_rdata=0xBEEF -> single mem_rd pulse with mem_addr=0x0040; stall_o=1 for 3 cycles with bubbles on MEM/WB; edge after done gives wb_data_o=0xBEEF.
- Zero-wait store: data_out=0x0010, data_two=0x00AA, Mem_write=1, mem_done same cycle -> mem_wr=1, mem_wdata=0x00AA, stall_o=0, wb_reg_write_o=Reg_write.
- mem_stall then misalignment:
  - Load at 0x0020 with mem_stall=1 for 2 cycles -> no mem_rd during those cycles, stall_o=1; then a normal issue.
  - Load at 0x0041 -> no mem_rd; err_o=1 and wb_halt_o=1 next edge.
- Timeout and reset: TIMEOUT=8, load with mem_done never asserted -> err_o=1 after 8 BUSY cycles.
  - Separate run: rst pulsed in BUSY cycle 2 -> IDLE, outputs 0.
  - A later mem_done is ignored.
